// File: rtl/rtype_exec_seq.sv
// rtype_exec_seq: multi-cycle R-type sequencer around an external ALU.
// Holds a 32x64 register file, decodes, drives the ALU, writes back.
module rtype_exec_seq #(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_cs,
  output logic [1:0]      alu_op,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  input  logic            alu_overflow,
  output logic            done,
  output logic            exc_overflow,
  output logic            exc_illegal,
  output logic            last_zero,
  input  logic            init_we,
  input  logic [4:0]      init_addr,
  input  logic [XLEN-1:0] init_data,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  logic [1:0]      state_q, state_d;
  logic [5:0]      op_q, fn_q;
  logic [4:0]      rs_q, rt_q, rd_q;
  logic            ill_q;
  logic [XLEN-1:0] res_q;
  logic            zero_q, ovf_q, lz_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [3:0]      cs_q;
  logic [1:0]      aop_q;
  logic [XLEN-1:0] rf_q [NREG];

  logic accept, legal, addsub, in_wb;
  logic init_wr, wb_wr, rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic unused_shamt;

  assign unused_shamt = ^instr[10:6];

  assign instr_ready = (state_q == S_IDLE) & rst_n;
  assign accept = instr_valid & instr_ready;
  assign in_wb  = (state_q == S_WB);

  assign addsub = (fn_q == F_ADD) | (fn_q == F_SUB);
  assign legal  = (op_q == 6'd0) &
                  (addsub | (fn_q == F_AND) |
                   (fn_q == F_OR) | (fn_q == F_SLT));

  assign done         = in_wb;
  assign exc_overflow = in_wb & ~ill_q & ovf_q & addsub;
  assign exc_illegal  = in_wb & ill_q;
  assign last_zero    = lz_q;

  assign alu_a  = a_q;
  assign alu_b  = b_q;
  assign alu_cs = cs_q;
  assign alu_op = aop_q;

  // Single write port: preload only in IDLE, writeback only in WB.
  assign init_wr = (state_q == S_IDLE) & init_we &
                   (init_addr != 5'd0);
  assign wb_wr   = in_wb & ~ill_q & (rd_q != 5'd0) &
                   ~(ovf_q & addsub);
  assign rf_we    = init_wr | wb_wr;
  assign rf_waddr = wb_wr ? rd_q : init_addr;
  assign rf_wdata = wb_wr ? res_q : init_data;

  assign dbg_data = (dbg_addr == 5'd0) ? '0 : rf_q[dbg_addr];

  // Next-state sequencing; illegal words skip EXEC.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_READ;
      S_READ: state_d = legal ? S_EXEC : S_WB;
      S_EXEC: state_d = S_WB;
      S_WB:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, instruction fields, ALU drive and result holding registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      fn_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      ill_q   <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      lz_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      cs_q    <= '0;
      aop_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q <= instr[31:26];
        rs_q <= instr[25:21];
        rt_q <= instr[20:16];
        rd_q <= instr[15:11];
        fn_q <= instr[5:0];
      end
      if (state_q == S_READ) begin
        a_q   <= rf_q[rs_q];
        b_q   <= rf_q[rt_q];
        cs_q  <= fn_q[3:0];
        aop_q <= 2'b10;
        ill_q <= ~legal;
      end
      if (state_q == S_EXEC) begin
        res_q  <= alu_result;
        zero_q <= alu_zero;
        ovf_q  <= alu_overflow;
      end
      if (in_wb && !ill_q) lz_q <= zero_q;
    end
  end

  // Register file; entry 0 is never written so it stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

endmodule

// File: tb/tb_rtype_exec_seq.sv
// tb_rtype_exec_seq: directed + random bench for rtype_exec_seq.
// Behavioural ALU in the loop, architectural register model.
module tb_rtype_exec_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [63:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_cs;
  logic [1:0]  alu_op;
  logic        alu_zero, alu_overflow;
  logic        done, exc_overflow, exc_illegal, last_zero;
  logic        init_we;
  logic [4:0]  init_addr, dbg_addr;
  logic [63:0] init_data, dbg_data;

  always #5 clk = ~clk;

  rtype_exec_seq #(.XLEN(64), .NREG(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_cs(alu_cs), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow),
    .done(done), .exc_overflow(exc_overflow),
    .exc_illegal(exc_illegal), .last_zero(last_zero),
    .init_we(init_we), .init_addr(init_addr),
    .init_data(init_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // External 64-bit ALU seen by the sequencer.
  always_comb begin
    logic signed [64:0] s;
    alu_result   = '0;
    alu_overflow = 1'b0;
    s            = '0;
    case (alu_cs)
      4'h0: begin
        s = $signed({alu_a[63], alu_a}) + $signed({alu_b[63], alu_b});
        alu_result = s[63:0];
        alu_overflow = s[64] != s[63];
      end
      4'h2: begin
        s = $signed({alu_a[63], alu_a}) - $signed({alu_b[63], alu_b});
        alu_result = s[63:0];
        alu_overflow = s[64] != s[63];
      end
      4'h4: alu_result = alu_a & alu_b;
      4'h5: alu_result = alu_a | alu_b;
      4'hA: alu_result = {63'd0, $signed(alu_a) < $signed(alu_b)};
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  logic [63:0] m_rf [32];
  bit          m_lz;
  int          nerr = 0;
  int          nchk = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op,
      input logic [4:0] rs, input logic [4:0] rt,
      input logic [4:0] rd, input logic [5:0] fn);
    logic [4:0] sh;
    sh = 5'($urandom_range(0, 31));
    return {op, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [63:0] rv();
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return 64'h7FFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return '1;
      4: return 64'($urandom_range(0, 9));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Architectural effect of one instruction on the model state.
  task automatic ref_step(input logic [31:0] w, output bit legal,
      output bit ovf, output logic [63:0] a, output logic [63:0] b);
    logic signed [64:0] wide;
    logic [63:0] r;
    logic [5:0] fn;
    logic [4:0] rd;
    fn = w[5:0];
    rd = w[15:11];
    a = m_rf[w[25:21]];
    b = m_rf[w[20:16]];
    legal = (w[31:26] == 0) && (fn == 6'h20 || fn == 6'h22 ||
            fn == 6'h24 || fn == 6'h25 || fn == 6'h2A);
    ovf = 0;
    r = 0;
    wide = 0;
    if (fn == 6'h20) wide = $signed(a) + $signed(b);
    if (fn == 6'h22) wide = $signed(a) - $signed(b);
    case (fn)
      6'h20, 6'h22: begin
        r = wide[63:0];
        ovf = legal && (wide > 65'sh0_7FFF_FFFF_FFFF_FFFF ||
                        wide < -65'sh0_8000_0000_0000_0000);
      end
      6'h24: r = a & b;
      6'h25: r = a | b;
      6'h2A: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      default: r = 0;
    endcase
    if (legal) begin
      m_lz = (r == 0);
      if (rd != 0 && !ovf) m_rf[rd] = r;
    end
  endtask

  task automatic dump_regs();
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      chk($sformatf("r%0d", i), dbg_data, m_rf[i]);
    end
    @(negedge clk);
  endtask

  task automatic preload(input logic [4:0] ad, input logic [63:0] d);
    init_we = 1; init_addr = ad; init_data = d;
    @(posedge clk);
    if (ad != 0) m_rf[ad] = d;
    @(negedge clk);
    init_we = 0;
  endtask

  // Issue one word from IDLE and follow it to completion.
  task automatic issue(input logic [31:0] w, input bit pre,
      input logic [4:0] pa, input logic [63:0] pd, input bit noise);
    bit legal, ovf;
    logic [63:0] a, b;
    int cyc, want;
    chk("ready", instr_ready, 1);
    instr = w; instr_valid = 1;
    if (pre) begin init_we = 1; init_addr = pa; init_data = pd; end
    @(posedge clk);
    if (pre && pa != 0) m_rf[pa] = pd;
    ref_step(w, legal, ovf, a, b);
    want = legal ? 3 : 2;
    @(negedge clk);
    instr_valid = 0; init_we = 0; instr = $urandom;
    if (noise) begin
      init_we = 1;
      init_addr = 5'($urandom_range(1, 31));
      init_data = {$urandom, $urandom};
    end
    cyc = 1;
    while (!done && cyc < 8) begin
      chk("exc_quiet", {62'd0, exc_overflow, exc_illegal}, 0);
      if (legal && cyc == 2) begin
        chk("alu_a", alu_a, a);
        chk("alu_b", alu_b, b);
        chk("alu_cs", alu_cs, w[3:0]);
        chk("alu_op", alu_op, 2'b10);
      end
      @(negedge clk);
      cyc++;
    end
    chk("done_cycle", cyc, want);
    chk("exc_overflow", exc_overflow, ovf);
    chk("exc_illegal", exc_illegal, !legal);
    init_we = 0;
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("last_zero", last_zero, m_lz);
    chk("hold_a", alu_a, a);
    chk("hold_b", alu_b, b);
    chk("hold_cs", alu_cs, w[3:0]);
    dump_regs();
  endtask

  initial begin
    bit lg, ov;
    logic [63:0] ta, tb;
    logic [31:0] wa, wb;
    rst_n = 0; instr_valid = 0; instr = 0;
    init_we = 0; init_addr = 0; init_data = 0; dbg_addr = 0;
    for (int i = 0; i < 32; i++) m_rf[i] = 0;
    m_lz = 0;
    @(negedge clk);
    chk("rst_ready", instr_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_lz", last_zero, 0);
    dump_regs();
    rst_n = 1;
    @(negedge clk);

    preload(1, 5);
    preload(2, 3);
    preload(0, 64'hDEAD);
    issue(32'h0022_1820, 0, 0, 0, 0);
    issue(32'h0041_2022, 0, 0, 0, 0);
    issue(32'h0041_282A, 0, 0, 0, 0);
    preload(6, 64'h7FFF_FFFF_FFFF_FFFF);
    issue(mk(0, 6, 1, 7, 6'h20), 0, 0, 0, 0);
    issue(mk(0, 1, 1, 10, 6'h22), 0, 0, 0, 0);
    issue(mk(0, 1, 2, 8, 6'h27), 0, 0, 0, 0);
    issue(mk(6'h08, 1, 2, 9, 6'h20), 0, 0, 0, 0);
    issue(mk(0, 1, 2, 0, 6'h24), 0, 0, 0, 0);
    issue(mk(0, 1, 2, 11, 6'h20), 1, 1, 64'd40, 0);

    // Two adds with instr_valid held high.
    wa = mk(0, 1, 2, 12, 6'h20);
    wb = mk(0, 12, 2, 13, 6'h20);
    instr = wa; instr_valid = 1;
    @(posedge clk);
    ref_step(wa, lg, ov, ta, tb);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 3) begin chk("b2b_done1", done, 1); instr = wb; end
      if (c == 4) begin
        chk("b2b_ready4", instr_ready, 1);
        ref_step(wb, lg, ov, ta, tb);
      end
      if (c == 5) begin chk("b2b_ready5", instr_ready, 0); instr_valid = 0; end
      if (c == 6) chk("b2b_nodone6", done, 0);
      if (c == 7) begin
        chk("b2b_done7", done, 1);
        chk("b2b_ovf", exc_overflow, ov);
      end
    end
    @(negedge clk);
    dump_regs();

    for (int k = 0; k < 60; k++) begin
      logic [5:0] op, fn;
      logic [5:0] fns [5];
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
      fn = fns[$urandom_range(0, 4)];
      if ($urandom_range(0, 5) == 0) fn = 6'($urandom);
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      if ($urandom_range(0, 2) == 0)
        preload(5'($urandom_range(0, 31)), rv());
      issue(mk(op, 5'($urandom), 5'($urandom), 5'($urandom), fn),
            bit'($urandom_range(0, 1)), 5'($urandom), rv(),
            bit'($urandom_range(0, 1)));
    end

    // Reset while add r3,r1,r2 sits in EXEC.
    instr = 32'h0022_1820; instr_valid = 1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 0;
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("mid_rst_ready", instr_ready, 0);
    chk("mid_rst_done", done, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_rst_nodone", done, 0);
    end
    for (int i = 0; i < 32; i++) m_rf[i] = 0;
    m_lz = 0;
    chk("mid_rst_a", alu_a, 0);
    chk("mid_rst_b", alu_b, 0);
    chk("mid_rst_cs", alu_cs, 0);
    chk("mid_rst_lz", last_zero, 0);
    dump_regs();
    rst_n = 1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", instr_ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_nodone", done, 0);
    end
    dump_regs();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
